// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage MIPS pipeline.
// Launches loads/stores on a req/ack data-memory port with byte-lane steering,
// extends load data, stalls upstream while an access is pending, abandons an
// access after TIMEOUT_CYCLES unacknowledged WAIT cycles, and registers the
// write-back bundle. Non-memory instructions pass through in one cycle.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [76:0] ex_mem_bundle,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [70:0] mem_wb_bundle,
    output logic        mem_wb_valid,
    output logic        align_fault,
    output logic        bus_fault
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t state, next_state;

    // Incoming execute-stage fields
    logic        in_valid, in_reg_write, in_mem_to_reg, in_mem_read, in_mem_write;
    logic [31:0] in_addr, in_store_data;
    logic [4:0]  in_reg_dest;
    logic        in_unsigned;
    logic [1:0]  in_size;

    assign in_valid      = ex_mem_bundle[76];
    assign in_reg_write  = ex_mem_bundle[75];
    assign in_mem_to_reg = ex_mem_bundle[74];
    assign in_mem_read   = ex_mem_bundle[73];
    assign in_mem_write  = ex_mem_bundle[72];
    assign in_addr       = ex_mem_bundle[71:40];
    assign in_store_data = ex_mem_bundle[39:8];
    assign in_reg_dest   = ex_mem_bundle[7:3];
    assign in_unsigned   = ex_mem_bundle[2];
    assign in_size       = ex_mem_bundle[1:0];

    // Instruction fields captured when an access is launched, so the result
    // does not depend on upstream behaviour during the wait.
    logic        lat_reg_write, lat_mem_to_reg, lat_load, lat_unsigned;
    logic [31:0] lat_addr;
    logic [4:0]  lat_reg_dest;
    logic [1:0]  lat_size;

    logic [CW-1:0] wait_count;

    logic        mem_op, misaligned, accept, complete, expire, timeout, pass_through;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] lane, load_data;

    assign mem_op       = in_valid & (in_mem_read | in_mem_write);
    assign timeout      = (wait_count == LAST_WAIT);
    assign accept       = (state == S_IDLE) & mem_op & ~misaligned;
    assign complete     = (state == S_WAIT) & dmem_ack;
    assign expire       = (state == S_WAIT) & ~dmem_ack & timeout;
    assign pass_through = (state == S_IDLE) & in_valid & ~mem_op;

    // Alignment check and lane steering for the incoming access
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = in_store_data;
        case (in_size)
            2'b10: begin
                be_next    = 4'b0001 << in_addr[1:0];
                wdata_next = {4{in_store_data[7:0]}};
            end
            2'b01: begin
                misaligned = in_addr[0];
                be_next    = 4'b0011 << in_addr[1:0];
                wdata_next = {2{in_store_data[15:0]}};
            end
            default: begin
                misaligned = (in_addr[1:0] != 2'b00);
            end
        endcase
    end

    // Lane selection and sign/zero extension of the returned read word
    always_comb begin
        lane      = dmem_rdata >> {lat_addr[1:0], 3'b000};
        load_data = lane;
        case (lat_size)
            2'b10:   load_data = lat_unsigned ? {24'b0, lane[7:0]}
                                              : {{24{lane[7]}}, lane[7:0]};
            2'b01:   load_data = lat_unsigned ? {16'b0, lane[15:0]}
                                              : {{16{lane[15]}}, lane[15:0]};
            default: load_data = lane;
        endcase
        if (!lat_load) begin
            load_data = 32'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic; an ack in the final WAIT cycle beats the timeout
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept) next_state = S_WAIT;
            S_WAIT: if (dmem_ack || timeout) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // FSM outputs: stall is combinational so upstream advances on the completing edge
    always_comb begin
        mem_stall = 1'b0;
        case (state)
            S_IDLE:  mem_stall = mem_op & ~misaligned;
            S_WAIT:  mem_stall = ~dmem_ack & ~timeout;
            default: mem_stall = 1'b0;
        endcase
    end

    // Memory port registers, wait counter and captured instruction fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= 32'b0;
            dmem_be        <= 4'b0;
            dmem_wdata     <= 32'b0;
            wait_count     <= '0;
            lat_reg_write  <= 1'b0;
            lat_mem_to_reg <= 1'b0;
            lat_load       <= 1'b0;
            lat_unsigned   <= 1'b0;
            lat_addr       <= 32'b0;
            lat_reg_dest   <= 5'b0;
            lat_size       <= 2'b0;
        end else begin
            dmem_req   <= (next_state == S_WAIT);
            wait_count <= (state == S_WAIT && next_state == S_WAIT) ? wait_count + CW'(1) : '0;
            if (accept) begin
                // mem_read wins when both read and write are set
                dmem_we        <= ~in_mem_read;
                dmem_addr      <= {in_addr[31:2], 2'b00};
                dmem_be        <= be_next;
                dmem_wdata     <= wdata_next;
                lat_reg_write  <= in_reg_write;
                lat_mem_to_reg <= in_mem_to_reg;
                lat_load       <= in_mem_read;
                lat_unsigned   <= in_unsigned;
                lat_addr       <= in_addr;
                lat_reg_dest   <= in_reg_dest;
                lat_size       <= in_size;
            end
        end
    end

    // Write-back bundle and fault pulses; bubbles clear only the valid flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_wb_bundle <= 71'b0;
            mem_wb_valid  <= 1'b0;
            align_fault   <= 1'b0;
            bus_fault     <= 1'b0;
        end else begin
            mem_wb_valid <= pass_through | complete;
            align_fault  <= (state == S_IDLE) & mem_op & misaligned;
            bus_fault    <= expire;
            if (pass_through) begin
                mem_wb_bundle <= {in_reg_write, in_mem_to_reg, 32'b0, in_addr, in_reg_dest};
            end else if (complete) begin
                mem_wb_bundle <= {lat_reg_write, lat_mem_to_reg, load_data, lat_addr, lat_reg_dest};
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// instruction streams, checked cycle by cycle against a transaction-level model.
module tb_mem_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [76:0] ex_mem_bundle;
    logic        mem_stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [70:0] mem_wb_bundle;
    logic        mem_wb_valid, align_fault, bus_fault;

    int n_tests = 0;
    int n_fail  = 0;
    logic [70:0] exp_wb = '0;

    mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_mem_bundle (ex_mem_bundle),
        .mem_stall     (mem_stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .mem_wb_bundle (mem_wb_bundle),
        .mem_wb_valid  (mem_wb_valid),
        .align_fault   (align_fault),
        .bus_fault     (bus_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [70:0] got, input logic [70:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [76:0] mk(input logic v, rw, m2r, mr, mw,
                                       input logic [31:0] a, sd, input logic [4:0] rd,
                                       input logic lu, input logic [1:0] sz);
        return {v, rw, m2r, mr, mw, a, sd, rd, lu, sz};
    endfunction

    // Reference model: access width in bytes and derived lane behaviour
    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'b10) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        int nb = nbytes(sz);
        int off = int'(a % 4);
        return 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] sd);
        int nb = nbytes(sz);
        if (nb == 1) return (sd % 256) * 32'h0101_0101;
        if (nb == 2) return (sd % 65536) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] a,
                                             input logic lu, input logic [31:0] rd_word);
        int nb = nbytes(sz);
        longint v = longint'(rd_word) >> (8 * (a % 4));
        longint span;
        if (nb == 4) return 32'(v);
        span = longint'(1) << (8 * nb);
        v = v % span;
        if (!lu && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // Drive one instruction and follow it to completion, checking every cycle.
    // ack_delay = number of WAIT cycles without ack before the ack cycle.
    task automatic run_op(input logic [76:0] b, input int ack_delay,
                          input logic [31:0] rdata, input bit spurious);
        logic        v, rw, m2r, mr, mw, lu, memop, bad, ack_now;
        logic [31:0] a, sd;
        logic [4:0]  rd;
        logic [1:0]  sz;
        {v, rw, m2r, mr, mw, a, sd, rd, lu, sz} = b;
        memop = v & (mr | mw);
        bad   = memop && ((a % nbytes(sz)) != 0);

        @(negedge clk);
        ex_mem_bundle = b;
        dmem_ack      = spurious;
        dmem_rdata    = rdata;
        #1;
        check("stall_idle", mem_stall, memop && !bad);
        @(posedge clk);
        #1;
        check("align_fault", align_fault, bad);
        check("bus_fault_idle", bus_fault, 1'b0);
        if (!memop || bad) begin
            if (v && !memop) exp_wb = {rw, m2r, 32'b0, a, rd};
            check("wb_valid", mem_wb_valid, v && !memop);
            check("wb_bundle", mem_wb_bundle, exp_wb);
            check("no_req", dmem_req, 1'b0);
        end else begin
            check("req_start", dmem_req, 1'b1);
            check("we", dmem_we, !mr);
            check("addr", dmem_addr, {a[31:2], 2'b00});
            check("be", dmem_be, ref_be(sz, a));
            check("wdata", dmem_wdata, ref_wdata(sz, sd));
            check("wb_valid_launch", mem_wb_valid, 1'b0);
            for (int w = 1; w <= T; w++) begin
                @(negedge clk);
                ack_now    = (ack_delay < T) && (w == ack_delay + 1);
                dmem_ack   = ack_now;
                dmem_rdata = rdata;
                #1;
                check("stall_wait", mem_stall, !ack_now && (w != T));
                check("addr_hold", dmem_addr, {a[31:2], 2'b00});
                @(posedge clk);
                #1;
                if (ack_now) begin
                    exp_wb = {rw, m2r, mr ? ref_load(sz, a, lu, rdata) : 32'b0, a, rd};
                    check("wb_valid_done", mem_wb_valid, 1'b1);
                    check("wb_bundle_done", mem_wb_bundle, exp_wb);
                    check("req_drop", dmem_req, 1'b0);
                    check("bus_fault_ack", bus_fault, 1'b0);
                    break;
                end else if (w == T) begin
                    check("bus_fault", bus_fault, 1'b1);
                    check("wb_valid_timeout", mem_wb_valid, 1'b0);
                    check("req_drop_timeout", dmem_req, 1'b0);
                    check("wb_bundle_hold", mem_wb_bundle, exp_wb);
                    break;
                end else begin
                    check("req_hold", dmem_req, 1'b1);
                    check("wb_valid_wait", mem_wb_valid, 1'b0);
                    check("bus_fault_wait", bus_fault, 1'b0);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, dmem_req, 1'b0);
        check({tag, "_we"}, dmem_we, 1'b0);
        check({tag, "_addr"}, dmem_addr, 32'b0);
        check({tag, "_be"}, dmem_be, 4'b0);
        check({tag, "_wdata"}, dmem_wdata, 32'b0);
        check({tag, "_wb"}, mem_wb_bundle, 71'b0);
        check({tag, "_valid"}, mem_wb_valid, 1'b0);
        check({tag, "_afault"}, align_fault, 1'b0);
        check({tag, "_bfault"}, bus_fault, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [76:0] b;
        reset         = 1'b1;
        ex_mem_bundle = '0;
        dmem_ack      = 1'b0;
        dmem_rdata    = '0;
        #1;
        check_all_zero("reset");
        check("reset_stall", mem_stall, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ALU pass-through
        run_op(mk(1, 1, 0, 0, 0, 32'h1234, 32'h0, 5'd5, 0, 2'b00), 0, 32'h0, 0);
        check("alu_bundle", mem_wb_bundle, {1'b1, 1'b0, 32'h0, 32'h1234, 5'd5});
        // Byte loads at offset 3, signed then unsigned
        run_op(mk(1, 1, 1, 1, 0, 32'h103, 32'h0, 5'd7, 0, 2'b10), 3, 32'h80FF_FFFF, 0);
        check("lb_signed", mem_wb_bundle[68:37], 32'hFFFF_FF80);
        run_op(mk(1, 1, 1, 1, 0, 32'h103, 32'h0, 5'd7, 1, 2'b10), 3, 32'h80FF_FFFF, 0);
        check("lb_unsigned", mem_wb_bundle[68:37], 32'h0000_0080);
        // Half store at offset 2, acked in first WAIT cycle
        run_op(mk(1, 0, 0, 0, 1, 32'h202, 32'hAAAA_5678, 5'd0, 0, 2'b01), 0, 32'h0, 0);
        check("sh_wdata", dmem_wdata, 32'h5678_5678);
        // Misaligned word load
        run_op(mk(1, 1, 1, 1, 0, 32'h101, 32'h0, 5'd3, 0, 2'b00), 0, 32'h0, 0);
        // Timeout, then a late ack during a bubble and during an ALU op
        run_op(mk(1, 1, 1, 1, 0, 32'h400, 32'h0, 5'd9, 0, 2'b00), T, 32'h0, 0);
        run_op(mk(0, 1, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 2'b00), 0, 32'hDEAD_BEEF, 1);
        run_op(mk(1, 1, 0, 0, 0, 32'h55, 32'h0, 5'd2, 0, 2'b00), 0, 32'hDEAD_BEEF, 1);

        // Reset during WAIT
        @(negedge clk);
        ex_mem_bundle = mk(1, 1, 1, 1, 0, 32'h40, 32'h0, 5'd4, 0, 2'b00);
        dmem_ack      = 1'b0;
        @(posedge clk);
        #1;
        check("rst_wait_req", dmem_req, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("rst_wait");
        check("rst_wait_stall", mem_stall, 1'b1);
        ex_mem_bundle = '0;
        #1;
        check("rst_bubble_stall", mem_stall, 1'b0);
        @(negedge clk);
        reset    = 1'b0;
        dmem_ack = 1'b1;
        @(posedge clk);
        #1;
        check("late_ack_valid", mem_wb_valid, 1'b0);
        check("late_ack_req", dmem_req, 1'b0);
        exp_wb = '0;
        run_op(mk(1, 1, 1, 1, 0, 32'h42, 32'h0, 5'd6, 0, 2'b01), 1, 32'h8001_1234, 0);
        run_op(mk(1, 1, 0, 0, 0, 32'h99, 32'h0, 5'd8, 0, 2'b00), 0, 32'h0, 0);

        // Random instruction stream
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            b = mk(($urandom % 10) != 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   a, $urandom, 5'($urandom), 1'($urandom), 2'($urandom));
            run_op(b, $urandom_range(0, T + 1), $urandom, ($urandom % 4) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
